// File: rtl/lsu_sram_master.sv
// Single-outstanding load/store initiator for the byte-addressed data SRAM.
// Three-stage flow IDLE -> ACCESS -> RESP; faulting accesses never drive a write enable.
module lsu_sram_master #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [3:0]        sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_write_data,
  input  logic [31:0]       sram_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              fault_q;
  logic [31:0]       rdata_q, rdata_d;

  logic              f3_legal;
  logic [2:0]        size_m1;
  logic [ADDR_W:0]   last_byte;
  logic              req_fault;
  logic              accept;

  // Size decode; unsigned sizes are only meaningful for loads.
  always_comb begin
    f3_legal = 1'b0;
    size_m1  = 3'd0;
    case (req_funct3)
      3'b000: begin f3_legal = 1'b1;    size_m1 = 3'd0; end
      3'b001: begin f3_legal = 1'b1;    size_m1 = 3'd1; end
      3'b010: begin f3_legal = 1'b1;    size_m1 = 3'd3; end
      3'b100: begin f3_legal = !req_we; size_m1 = 3'd0; end
      3'b101: begin f3_legal = !req_we; size_m1 = 3'd1; end
      default: begin f3_legal = 1'b0;   size_m1 = 3'd0; end
    endcase
  end

  // A carry into bit ADDR_W means the access would wrap past the top of the SRAM.
  assign last_byte = {1'b0, req_addr[ADDR_W-1:0]} + (ADDR_W+1)'(size_m1);
  assign req_fault = ((req_addr >> ADDR_W) != 32'd0) || last_byte[ADDR_W] || !f3_legal;
  assign accept    = (state_q == IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && !rst;
    rsp_valid = (state_q == RESP);
    sram_w_en = 4'b0000;
    if ((state_q == ACCESS) && !rst && we_q && !fault_q) begin
      case (funct3_q[1:0])
        2'b00:   sram_w_en = 4'b0001;
        2'b01:   sram_w_en = 4'b0011;
        2'b10:   sram_w_en = 4'b1111;
        default: sram_w_en = 4'b0000;
      endcase
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (state_q == ACCESS) begin
      if (we_q || fault_q) begin
        rdata_d = 32'd0;
      end else begin
        case (funct3_q)
          3'b000:  rdata_d = {{24{sram_read_data[7]}}, sram_read_data[7:0]};
          3'b100:  rdata_d = {24'd0, sram_read_data[7:0]};
          3'b001:  rdata_d = {{16{sram_read_data[15]}}, sram_read_data[15:0]};
          3'b101:  rdata_d = {16'd0, sram_read_data[15:0]};
          default: rdata_d = sram_read_data;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[ADDR_W-1:0];
        wdata_q  <= req_wdata;
        fault_q  <= req_fault;
      end
      rdata_q <= rdata_d;
    end
  end

  assign sram_address    = addr_q;
  assign sram_write_data = wdata_q;
  assign rsp_rdata       = rdata_q;
  assign rsp_fault       = fault_q;

endmodule

// File: tb/tb_lsu_sram_master.sv
// Bench for lsu_sram_master: directed vector table, hand-written backpressure/reset
// sequences, then random transactions scored against a byte-array reference model.
module tb_lsu_sram_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [3:0]  sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_write_data, sram_read_data;

  int n_vec = 0;
  int n_miss = 0;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always #5 clk = ~clk;

  lsu_sram_master #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .sram_w_en(sram_w_en), .sram_address(sram_address),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
  );

  // SRAM model: combinational read, byte-lane write on the rising edge.
  logic [15:0] ra0, ra1, ra2, ra3;
  always_comb begin
    ra0 = sram_address;
    ra1 = sram_address + 16'd1;
    ra2 = sram_address + 16'd2;
    ra3 = sram_address + 16'd3;
    sram_read_data = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
  end

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (sram_w_en[b]) mem[16'(sram_address + 16'(b))] = sram_write_data[8*b +: 8];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: legality and extension from plain arithmetic over a byte array.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic fault,
                                output logic [31:0] rdata, output logic [3:0] wen);
    int     size;
    bit     legal;
    longint val;
    size  = 1;
    legal = 1'b0;
    case (f3)
      3'd0: begin size = 1; legal = 1'b1; end
      3'd1: begin size = 2; legal = 1'b1; end
      3'd2: begin size = 4; legal = 1'b1; end
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: begin size = 1; legal = 1'b0; end
    endcase
    fault = !legal || (longint'(addr) > 65535) || (longint'(addr) + size > 65536);
    rdata = 32'd0;
    wen   = 4'd0;
    if (!fault) begin
      if (we) begin
        wen = 4'((1 << size) - 1);
        for (int b = 0; b < size; b++) ref_mem[addr + 32'(b)] = wdata[8*b +: 8];
      end else begin
        val = 0;
        for (int b = size - 1; b >= 0; b--) val = val * 256 + longint'(ref_mem[addr + 32'(b)]);
        if ((f3 == 3'd0 && val >= 128) || (f3 == 3'd1 && val >= 32768))
          val = val - (longint'(1) << (8 * size));
        rdata = 32'(val);
      end
    end
  endfunction

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int bp, input logic [3:0] exp_wen,
                         input logic exp_fault, input logic [31:0] exp_rdata);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    check("w_en_idle", sram_w_en, 0);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    #1;
    check("w_en_access", sram_w_en, exp_wen);
    check("addr_access", sram_address, addr[15:0]);
    if (we) check("wdata_access", sram_write_data, wdata);
    check("req_ready_access", req_ready, 0);
    check("rsp_valid_access", rsp_valid, 0);
    @(negedge clk);
    check("rsp_valid_resp", rsp_valid, 1);
    check("rsp_fault", rsp_fault, exp_fault);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("w_en_resp", sram_w_en, 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", {rsp_fault, rsp_rdata}, {exp_fault, exp_rdata});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after", rsp_valid, 0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_fault;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_wen;
  } vec_t;

  vec_t tbl [22];

  initial begin
    logic        m_fault;
    logic [31:0] m_rdata;
    logic [3:0]  m_wen;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;
    int          sel;

    for (int i = 0; i < 65536; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end

    tbl[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0000_0000, 4'hF};
    tbl[1]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_5678, 4'h0};
    tbl[2]  = '{1'b1, 3'b000, 32'h0000_0020, 32'hDEAD_0080, 1'b0, 32'h0000_0000, 4'h1};
    tbl[3]  = '{1'b1, 3'b001, 32'h0000_0022, 32'h1234_FF7F, 1'b0, 32'h0000_0000, 4'h3};
    tbl[4]  = '{1'b0, 3'b000, 32'h0000_0020, 32'h0,         1'b0, 32'hFFFF_FF80, 4'h0};
    tbl[5]  = '{1'b0, 3'b100, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0080, 4'h0};
    tbl[6]  = '{1'b0, 3'b001, 32'h0000_0022, 32'h0,         1'b0, 32'hFFFF_FF7F, 4'h0};
    tbl[7]  = '{1'b0, 3'b101, 32'h0000_0022, 32'h0,         1'b0, 32'h0000_FF7F, 4'h0};
    tbl[8]  = '{1'b1, 3'b010, 32'h0000_0040, 32'hAABB_CCDD, 1'b0, 32'h0000_0000, 4'hF};
    tbl[9]  = '{1'b1, 3'b000, 32'h0000_0041, 32'h0000_0011, 1'b0, 32'h0000_0000, 4'h1};
    tbl[10] = '{1'b0, 3'b010, 32'h0000_0040, 32'h0,         1'b0, 32'hAABB_11DD, 4'h0};
    tbl[11] = '{1'b1, 3'b010, 32'h0001_0000, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'h0};
    tbl[12] = '{1'b0, 3'b010, 32'h0000_FFFD, 32'h0,         1'b1, 32'h0000_0000, 4'h0};
    tbl[13] = '{1'b1, 3'b100, 32'h0000_0050, 32'h0000_00AA, 1'b1, 32'h0000_0000, 4'h0};
    tbl[14] = '{1'b0, 3'b011, 32'h0000_0050, 32'h0,         1'b1, 32'h0000_0000, 4'h0};
    tbl[15] = '{1'b1, 3'b001, 32'h0000_FFFE, 32'h0000_BEEF, 1'b0, 32'h0000_0000, 4'h3};
    tbl[16] = '{1'b0, 3'b101, 32'h0000_FFFE, 32'h0,         1'b0, 32'h0000_BEEF, 4'h0};
    tbl[17] = '{1'b0, 3'b001, 32'h0000_FFFF, 32'h0,         1'b1, 32'h0000_0000, 4'h0};
    tbl[18] = '{1'b1, 3'b000, 32'h0000_FFFF, 32'h0000_007A, 1'b0, 32'h0000_0000, 4'h1};
    tbl[19] = '{1'b0, 3'b010, 32'h0000_FFFC, 32'h0,         1'b0, 32'h7AEF_0000, 4'h0};
    tbl[20] = '{1'b0, 3'b010, 32'h0000_0041, 32'h0,         1'b0, 32'h00AA_BB11, 4'h0};
    tbl[21] = '{1'b1, 3'b101, 32'h0000_0060, 32'h0000_1234, 1'b1, 32'h0000_0000, 4'h0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("req_ready_in_rst", req_ready, 0);
    check("w_en_in_rst", sram_w_en, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_fault", rsp_fault, 0);
    check("reset_sram_addr", sram_address, 0);
    check("reset_sram_wdata", sram_write_data, 0);

    for (int i = 0; i < 22; i++) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_fault, m_rdata, m_wen);
      run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, i % 3,
              tbl[i].exp_wen, tbl[i].exp_fault, tbl[i].exp_rdata);
    end

    // Backpressure: LW held 5 cycles while a competing store is presented.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10;
    req_wdata = 32'h0000_0055;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
      check("bp_req_ready", req_ready, 0);
      check("bp_w_en", sram_w_en, 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_ready", req_ready, 1);
    run_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 4'h0, 1'b0, 32'h1234_5678);

    // Reset during the ACCESS cycle of a store must suppress the write.
    model(1'b1, 3'b010, 32'h80, 32'h0102_0304, m_fault, m_rdata, m_wen);
    run_txn(1'b1, 3'b010, 32'h80, 32'h0102_0304, 0, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h80;
    req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_access_w_en", sram_w_en, 0);
    check("rst_access_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_valid", rsp_valid, 0);
    check("post_rst_ready", req_ready, 1);
    run_txn(1'b0, 3'b010, 32'h80, 32'h0, 1, 4'h0, 1'b0, 32'h0102_0304);

    for (int n = 0; n < 250; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_wdata = $urandom;
      sel     = int'($urandom_range(0, 9));
      if (sel <= 6)      r_addr = 32'h100 + 32'($urandom_range(0, 63));
      else if (sel <= 8) r_addr = 32'hFFF8 + 32'($urandom_range(0, 7));
      else               r_addr = $urandom | 32'h0001_0000;
      model(r_we, r_f3, r_addr, r_wdata, m_fault, m_rdata, m_wen);
      run_txn(r_we, r_f3, r_addr, r_wdata, int'($urandom_range(0, 3)), m_wen, m_fault, m_rdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lsu_sram_master.md
# lsu_sram_master

Load/store initiator for the CPU data path that drives the byte-addressed single-port data SRAM (4-bit `w_en`, 16-bit `address`, 32-bit `write_data`, combinational `read_data`). It accepts one load or store at a time from the execute stage over a valid/ready handshake. It converts RV32 `funct3` size codes into SRAM byte-enable patterns and returns sign- or zero-extended load data over a valid/ready response channel. Out-of-range or illegal accesses are flagged, and the SRAM is never touched for them.

## Interface
Parameters:
- `ADDR_W`, default 16: SRAM byte-address width. Legal span is 0 to 2^ADDR_W−1.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: unit can accept a request.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_funct3`, in, 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: store data, LSB-aligned.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer takes the response.
- `rsp_rdata`, out, 32: extended load data. 0 for stores and faults.
- `rsp_fault`, out, 1: access rejected.
- `sram_w_en`, out, 4: byte-enable to SRAM.
- `sram_address`, out, ADDR_W: SRAM byte address.
- `sram_write_data`, out, 32: SRAM write data.
- `sram_read_data`, in, 32: SRAM combinational read data.

## Operation
- FSM states:
  - IDLE:
    - `req_ready`=1.
    - On `req_valid`: latch `we`, `funct3`, `addr`, `wdata`, and the computed fault flag, then go to ACCESS.
  - ACCESS (exactly 1 cycle):
    - `sram_address` = latched `addr[ADDR_W-1:0]`.
    - `sram_write_data` = latched `wdata`.
    - Store with no fault: `sram_w_en` is B→0001, H→0011, W→1111. The SRAM commits the write on the edge that ends ACCESS.
    - Load with no fault: `sram_w_en`=0000. On the edge that ends ACCESS, capture `sram_read_data` into `rsp_rdata` with extension:
      - B: sign-extend [7:0].
      - BU: zero-extend [7:0].
      - H: sign-extend [15:0].
      - HU: zero-extend [15:0].
      - W: full 32 bits.
    - Fault: `sram_w_en`=0000 and `rsp_rdata`=0.
    - Next state is RESP.
  - RESP:
    - `rsp_valid`=1.
    - Hold `rsp_rdata` and `rsp_fault` stable until `rsp_ready`=1, then go to IDLE.
- Fault conditions (computed at accept time):
  - `req_addr[31:ADDR_W]` ≠ 0.
  - `addr[ADDR_W-1:0]` + size − 1 exceeds 2^ADDR_W−1. No wrap-around access is allowed, e.g. a word at 0xFFFD.
  - Store with `funct3` ∉ {000, 001, 010}.
  - Load with `funct3` ∉ {000, 001, 010, 100, 101}.
- Misaligned but in-range accesses are legal. The SRAM is byte-addressed, so no alignment fault exists.
- `sram_w_en` is 0000 in every state other than ACCESS, and whenever `rst`=1. No write may ever occur in a reset cycle.
- Outside ACCESS, `sram_address` and `sram_write_data` hold their last latched values. Verification must not check them.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready`=1 once `rst` deasserts.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0.
  - `sram_w_en`=0000, `sram_address`=0, `sram_write_data`=0.
  - All latched request registers 0.
- `req_ready` is 0 while `rst`=1.
- Latency: accept edge N, ACCESS during cycle N+1, `rsp_valid` high from cycle N+2.
- Minimum occupancy is 3 cycles per transaction. A new request is accepted no earlier than the cycle after the RESP handshake.
- `req_ready` is combinational from state only. It does not depend on `req_valid`.
- `rsp_valid` never drops without `rsp_ready`. Response values do not change while `rsp_valid`=1 and `rsp_ready`=0.
- `rst` asserted in any state:
  - Next state is IDLE.
  - Any pending response is discarded.
  - A store in ACCESS during the reset cycle is not written, because `w_en` is gated.
- `req_valid` outside IDLE is ignored. The requester must hold it until it sees `req_ready`.

## Test plan
- Store-word then load-word:
  - SW 0x12345678 @0x0010: `sram_w_en`=1111 for one cycle, then `rsp_valid` with `rsp_fault`=0.
  - LW @0x0010: `rsp_rdata`=0x12345678.
- Byte and halfword extension:
  - Preload 0x80 @0x0020 and 0xFF7F @0x0022.
  - LB @0x0020 → 0xFFFFFF80. LBU @0x0020 → 0x00000080.
  - LH @0x0022 → 0xFFFFFF7F. LHU @0x0022 → 0x0000FF7F.
- Partial store:
  - SW 0xAABBCCDD @0x0040, then SB 0x11 @0x0041 (`w_en`=0001, address 0x0041), then LW @0x0040 → 0xAABB11DD.
- Faults: each case gives `rsp_fault`=1, `rsp_rdata`=0, and `sram_w_en` stays 0000 throughout.
  - SW @0x00010000.
  - LW @0xFFFD.
  - Store with `funct3`=100.
  - Load with `funct3`=011.
- Backpressure:
  - Hold `rsp_ready`=0 for 5 cycles after an LW: `rsp_valid` and `rsp_rdata` are stable, `req_ready`=0, and a concurrent `req_valid` is not accepted.
  - Raise `rsp_ready`: state returns to IDLE the next cycle.
- Reset mid-operation:
  - Assert `rst` during the ACCESS cycle of SW 0xDEADBEEF @0x0080: `sram_w_en`=0000 in that cycle.
  - After reset: `rsp_valid`=0 and `req_ready`=1. A subsequent LW @0x0080 returns the prior contents, not 0xDEADBEEF.
